// File: rtl/lock_pkg.sv
// Shared types and constants for the lock code transmitter: FSM states,
// the all-released key pattern and the contact-bounce length.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    DONE
  } lock_state_e;

  localparam logic [3:0] KEY_IDLE   = 4'b1111;
  localparam int         BOUNCE_LEN = 4;

  // Active-low key pattern with only key k pressed.
  function automatic logic [3:0] key_low(input logic [1:0] k);
    return KEY_IDLE & ~(4'b0001 << k);
  endfunction

endpackage

// File: rtl/lock_tx_timer.sv
// Loadable down-counter with a zero flag; it holds at zero rather than wrapping.
module lock_tx_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/lock_code_tx.sv
// Emulates a keypad typing a CODE_LEN-digit code on four active-low buttons.
// Optional macro LOCK_TX_BOUNCE_EN adds contact bounce at every press and release edge.
module lock_code_tx
  import lock_pkg::*;
#(
  parameter int CODE_LEN  = 4,
  parameter int PRESS_CYC = 1000000,
  parameter int GAP_CYC   = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [2*CODE_LEN-1:0] code_i,
  output logic [3:0]            key_out_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int MAX_CYC = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int DW      = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  lock_state_e           state_q;
  logic [2*CODE_LEN-1:0] code_q;
  logic [DW-1:0]         digit_q;
  logic [3:0]            key_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  loadEn;
  logic [CW-1:0]         loadVal;
  logic [CW-1:0]         timerCnt;
  logic                  timerZero;
  logic                  lastDigit;
  logic [2*CODE_LEN-1:0] codeShift;
  logic [1:0]            curKey;
  logic [1:0]            nextKey;

  assign lastDigit = (digit_q == DW'(CODE_LEN - 1));
  assign codeShift = code_q >> 2;
  assign curKey    = code_q[1:0];
  assign nextKey   = codeShift[1:0];

  // Reload the timer on every state entry so each state runs its full length.
  always_comb begin
    loadEn  = 1'b0;
    loadVal = CW'(PRESS_CYC - 1);
    unique case (state_q)
      IDLE:  if (start_i && !abort_i) loadEn = 1'b1;
      PRESS: if (!abort_i && timerZero) begin
        loadEn  = 1'b1;
        loadVal = CW'(GAP_CYC - 1);
      end
      GAP:   if (!abort_i && timerZero && !lastDigit) loadEn = 1'b1;
      default: ;
    endcase
  end

  lock_tx_timer #(.W(CW)) uTimer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (loadEn),
    .load_val_i(loadVal),
    .count_o   (timerCnt),
    .zero_o    (timerZero)
  );

`ifdef LOCK_TX_BOUNCE_EN
  // Index within the state of the cycle being registered next; odd early cycles bounce.
  logic [CW-1:0] pressElapsed;
  logic [CW-1:0] gapElapsed;
  logic          pressBounce;
  logic          gapBounce;

  assign pressElapsed = CW'(PRESS_CYC) - timerCnt;
  assign gapElapsed   = CW'(GAP_CYC) - timerCnt;
  assign pressBounce  = (pressElapsed < CW'(BOUNCE_LEN)) && pressElapsed[0];
  assign gapBounce    = (gapElapsed < CW'(BOUNCE_LEN)) && gapElapsed[0];
`else
  logic unusedCnt;
  assign unusedCnt = ^timerCnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      digit_q <= '0;
      key_q   <= KEY_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          key_q  <= KEY_IDLE;
          busy_q <= 1'b0;
          if (start_i && !abort_i) begin
            code_q  <= code_i;
            digit_q <= '0;
            key_q   <= key_low(code_i[1:0]);
            busy_q  <= 1'b1;
            state_q <= PRESS;
          end
        end
        PRESS: begin
          if (abort_i) begin
            key_q   <= KEY_IDLE;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (timerZero) begin
            key_q   <= KEY_IDLE;
            state_q <= GAP;
          end else begin
`ifdef LOCK_TX_BOUNCE_EN
            key_q <= pressBounce ? KEY_IDLE : key_low(curKey);
`else
            key_q <= key_low(curKey);
`endif
          end
        end
        GAP: begin
          if (abort_i) begin
            key_q   <= KEY_IDLE;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (timerZero) begin
            if (lastDigit) begin
              key_q   <= KEY_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              code_q  <= codeShift;
              digit_q <= digit_q + 1'b1;
              key_q   <= key_low(nextKey);
              state_q <= PRESS;
            end
          end else begin
`ifdef LOCK_TX_BOUNCE_EN
            key_q <= gapBounce ? key_low(curKey) : KEY_IDLE;
`else
            key_q <= KEY_IDLE;
`endif
          end
        end
        DONE: begin
          key_q   <= KEY_IDLE;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          key_q   <= KEY_IDLE;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign key_out_o = key_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
